// File: rtl/mem_pkg.sv
// Shared definitions for the memory pipeline stage.
//   - Instruction type codes as seen on the execute/memory register.
//   - funct3 access-size codes for loads and stores.
//   - Memory stage FSM state constants (IDLE, WAIT).
//   - Helpers for store byte strobes, store lane replication and
//     access alignment checking.
// WORD_SIZE defaults to 32 when not supplied on the command line; the
// byte-lane logic assumes a 32-bit word.
// Optional feature macro: MISALIGN_EXC_EN (used by mem_stage).

`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

package mem_pkg;

    localparam int WORD_SIZE_DEFAULT = `WORD_SIZE;

    localparam logic [1:0] ITYPE_ALU    = 2'd0;
    localparam logic [1:0] ITYPE_LOAD   = 2'd1;
    localparam logic [1:0] ITYPE_STORE  = 2'd2;
    localparam logic [1:0] ITYPE_BRANCH = 2'd3;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_WAIT = 1'b1;

    // Byte strobes for a store; any funct3 that is not a byte or half
    // store is treated as a full word store.
    function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] offset);
        logic [3:0] strb;
        case (f3)
            F3_B:    strb = 4'b0001 << offset;
            F3_H:    strb = 4'b0011 << {offset[1], 1'b0};
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

    // Store data is replicated across every lane it could land in so the
    // strobes alone select the bytes written.
    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] data);
        logic [31:0] wdata;
        case (f3)
            F3_B:    wdata = {4{data[7:0]}};
            F3_H:    wdata = {2{data[15:0]}};
            default: wdata = data;
        endcase
        return wdata;
    endfunction

    // Only true half and word accesses can be misaligned; HU exists only
    // for loads, so a store with that code is an "other" (word) store.
    function automatic logic is_misaligned(input logic is_store, input logic [2:0] f3,
                                           input logic [1:0] offset);
        logic mis;
        mis = 1'b0;
        if (f3 == F3_W)
            mis = (offset != 2'b00);
        else if (f3 == F3_H || (!is_store && f3 == F3_HU))
            mis = offset[0];
        return mis;
    endfunction

endpackage

// File: rtl/load_formatter.sv
// Load data formatter for the memory stage (purely combinational).
// Selects the addressed byte or halfword lane of the returned memory
// word and sign- or zero-extends it to the full word.
// Ports:
//   rdata   in   WORD_SIZE  word returned by data memory
//   funct3  in   3          load size/sign code
//   offset  in   2          low address bits of the load
//   result  out  WORD_SIZE  formatted load value

module load_formatter
    import mem_pkg::*;
#(
    parameter int WORD_SIZE = 32
) (
    input  logic [WORD_SIZE-1:0] rdata,
    input  logic [2:0]           funct3,
    input  logic [1:0]           offset,
    output logic [WORD_SIZE-1:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Halfword lane ignores offset[0]; an odd half offset either raised an
    // exception earlier or is deliberately rounded down.
    always_comb begin
        byte_lane = rdata[7:0];
        case (offset)
            2'd0: byte_lane = rdata[7:0];
            2'd1: byte_lane = rdata[15:8];
            2'd2: byte_lane = rdata[23:16];
            2'd3: byte_lane = rdata[31:24];
            default: byte_lane = rdata[7:0];
        endcase
        half_lane = offset[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_B:    result = {{(WORD_SIZE-8){byte_lane[7]}}, byte_lane};
            F3_BU:   result = {{(WORD_SIZE-8){1'b0}}, byte_lane};
            F3_H:    result = {{(WORD_SIZE-16){half_lane[15]}}, half_lane};
            F3_HU:   result = {{(WORD_SIZE-16){1'b0}}, half_lane};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage of the pipeline.
// Consumes the execute/memory register, performs loads and stores through a
// req/ready data memory handshake, formats load data and hands completions
// (rob_id, pc, result) to writeback. ALU and branch results pass straight
// through with one cycle of latency.
// Ports:
//   clk, reset                   clock and asynchronous active-high reset
//   valid, instruction_type, pc, funct3, aluResult, s2, rob_id
//                                incoming instruction from execute/memory
//   stall_out                    hold the execute/memory register
//   mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
//                                data memory request (held until mem_ready)
//   mem_ready, mem_rdata         data memory response
//   wb_stall                     writeback cannot accept this cycle
//   wb_valid, wb_rob_id, wb_pc, wb_result, wb_exc
//                                completion towards writeback
// Optional feature: define MISALIGN_EXC_EN to turn misaligned half/word
// accesses into single-cycle exceptions instead of silently rounding the
// address down. Without it wb_exc is constant 0.

`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module mem_stage
    import mem_pkg::*;
#(
    parameter int WORD_SIZE = `WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid,
    input  logic [1:0]           instruction_type,
    input  logic [WORD_SIZE-1:0] pc,
    input  logic [2:0]           funct3,
    input  logic [WORD_SIZE-1:0] aluResult,
    input  logic [WORD_SIZE-1:0] s2,
    input  logic [6:0]           rob_id,
    output logic                 stall_out,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    output logic [3:0]           mem_wstrb,
    input  logic                 mem_ready,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 wb_stall,
    output logic                 wb_valid,
    output logic [6:0]           wb_rob_id,
    output logic [WORD_SIZE-1:0] wb_pc,
    output logic [WORD_SIZE-1:0] wb_result,
    output logic                 wb_exc
);

    state_t               state;
    logic [WORD_SIZE-1:0] addr_q;
    logic [WORD_SIZE-1:0] data_q;
    logic [2:0]           funct3_q;
    logic                 store_q;
    logic [6:0]           rob_q;
    logic [WORD_SIZE-1:0] pc_q;
    logic [WORD_SIZE-1:0] load_data;
    logic                 accept;
    logic                 wb_hold;
    logic                 is_mem_op;

    load_formatter #(
        .WORD_SIZE(WORD_SIZE)
    ) u_load_formatter (
        .rdata  (mem_rdata),
        .funct3 (funct3_q),
        .offset (addr_q[1:0]),
        .result (load_data)
    );

    // A completion stuck behind wb_stall blocks new work so it can never be
    // overwritten; WAIT blocks new work until the memory answers.
    assign wb_hold   = wb_valid && wb_stall;
    assign stall_out = (state == ST_WAIT) || wb_hold;
    assign accept    = valid && !stall_out;
    assign is_mem_op = (instruction_type == ITYPE_LOAD) || (instruction_type == ITYPE_STORE);

    // Request is a pure function of state and latched operands, so it stays
    // stable until mem_ready and drops as soon as reset clears the state.
    assign mem_req   = (state == ST_WAIT);
    assign mem_we    = mem_req && store_q;
    assign mem_addr  = {addr_q[WORD_SIZE-1:2], 2'b00};
    assign mem_wdata = store_data(funct3_q, data_q);
    assign mem_wstrb = mem_we ? store_strobe(funct3_q, addr_q[1:0]) : 4'b0000;

`ifdef MISALIGN_EXC_EN
    logic exc_q;
    assign wb_exc = exc_q;
`else
    assign wb_exc = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            funct3_q  <= '0;
            store_q   <= 1'b0;
            rob_q     <= '0;
            pc_q      <= '0;
            wb_valid  <= 1'b0;
            wb_rob_id <= '0;
            wb_pc     <= '0;
            wb_result <= '0;
`ifdef MISALIGN_EXC_EN
            exc_q     <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_mem_op) begin
`ifdef MISALIGN_EXC_EN
                            if (is_misaligned(instruction_type == ITYPE_STORE, funct3, aluResult[1:0])) begin
                                wb_valid  <= 1'b1;
                                wb_rob_id <= rob_id;
                                wb_pc     <= pc;
                                wb_result <= aluResult;
                                exc_q     <= 1'b1;
                            end else
`endif
                            begin
                                addr_q   <= aluResult;
                                data_q   <= s2;
                                funct3_q <= funct3;
                                store_q  <= (instruction_type == ITYPE_STORE);
                                rob_q    <= rob_id;
                                pc_q     <= pc;
                                wb_valid <= 1'b0;
                                state    <= ST_WAIT;
`ifdef MISALIGN_EXC_EN
                                exc_q    <= 1'b0;
`endif
                            end
                        end else begin
                            wb_valid  <= 1'b1;
                            wb_rob_id <= rob_id;
                            wb_pc     <= pc;
                            wb_result <= aluResult;
`ifdef MISALIGN_EXC_EN
                            exc_q     <= 1'b0;
`endif
                        end
                    end else if (!wb_hold) begin
                        wb_valid <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (mem_ready) begin
                        wb_valid  <= 1'b1;
                        wb_rob_id <= rob_q;
                        wb_pc     <= pc_q;
                        wb_result <= store_q ? '0 : load_data;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage.
// Expected completions and expected memory requests are queued when an
// instruction is driven; a memory responder pops request expectations when
// mem_req appears and a writeback monitor pops completions when they are
// consumed. Build with MISALIGN_EXC_EN to expect misalignment exceptions.

module tb_mem_stage;
    import mem_pkg::*;

    logic        clk;
    logic        reset;
    logic        valid;
    logic [1:0]  instruction_type;
    logic [31:0] pc;
    logic [2:0]  funct3;
    logic [31:0] aluResult;
    logic [31:0] s2;
    logic [6:0]  rob_id;
    logic        stall_out;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        wb_stall;
    logic        wb_valid;
    logic [6:0]  wb_rob_id;
    logic [31:0] wb_pc;
    logic [31:0] wb_result;
    logic        wb_exc;

    typedef struct {
        logic [6:0]  rob;
        logic [31:0] pc;
        logic [31:0] result;
        logic        exc;
    } wb_exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        int          delay;
    } mem_exp_t;

    wb_exp_t  wbQueue[$];
    mem_exp_t memQueue[$];

    int checkCount = 0;
    int errorCount = 0;

    mem_stage dut (
        .clk              (clk),
        .reset            (reset),
        .valid            (valid),
        .instruction_type (instruction_type),
        .pc               (pc),
        .funct3           (funct3),
        .aluResult        (aluResult),
        .s2               (s2),
        .rob_id           (rob_id),
        .stall_out        (stall_out),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_wstrb        (mem_wstrb),
        .mem_ready        (mem_ready),
        .mem_rdata        (mem_rdata),
        .wb_stall         (wb_stall),
        .wb_valid         (wb_valid),
        .wb_rob_id        (wb_rob_id),
        .wb_pc            (wb_pc),
        .wb_result        (wb_result),
        .wb_exc           (wb_exc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Reference formatting: shift the word so the addressed lane sits at bit 0.
    function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] word);
        logic [31:0] b;
        logic [31:0] h;
        b = word >> (8 * a);
        h = word >> (a[1] ? 16 : 0);
        case (f3)
            3'b000:  return {{24{b[7]}}, b[7:0]};
            3'b100:  return {24'h0, b[7:0]};
            3'b001:  return {{16{h[15]}}, h[15:0]};
            3'b101:  return {16'h0, h[15:0]};
            default: return word;
        endcase
    endfunction

    function automatic logic [3:0] modelStrb(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] s;
        for (int i = 0; i < 4; i++) begin
            if (f3 == 3'b000)      s[i] = (i == int'(a));
            else if (f3 == 3'b001) s[i] = ((i / 2) == int'(a[1]));
            else                   s[i] = 1'b1;
        end
        return s;
    endfunction

    function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) begin
            if (f3 == 3'b000)      w[i*8 +: 8] = d[7:0];
            else if (f3 == 3'b001) w[i*8 +: 8] = d[(i % 2)*8 +: 8];
            else                   w[i*8 +: 8] = d[i*8 +: 8];
        end
        return w;
    endfunction

`ifdef MISALIGN_EXC_EN
    function automatic logic modelMisaligned(input logic isStore, input logic [2:0] f3, input logic [1:0] a);
        if (f3 == 3'b010) return (a != 2'b00);
        if (f3 == 3'b001 || (!isStore && f3 == 3'b101)) return a[0];
        return 1'b0;
    endfunction
`endif

    // Drives one valid instruction at a falling edge once the stage can
    // accept it, queues its expectations, and returns at the falling edge
    // after acceptance with valid dropped.
    task automatic applyStimulus(input logic [1:0] t, input logic [31:0] p, input logic [2:0] f3,
                                 input logic [31:0] alu, input logic [31:0] sd, input logic [6:0] rob,
                                 input int delay, input logic [31:0] rdata);
        int waited;
        wb_exp_t  w;
        mem_exp_t m;
        logic isStore;
        logic mis;
        @(negedge clk);
        waited = 0;
        while (stall_out && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (stall_out) begin
            checkOutput("accept_timeout", 32'(stall_out), 32'd0);
            return;
        end
        valid = 1'b1;
        instruction_type = t;
        pc = p;
        funct3 = f3;
        aluResult = alu;
        s2 = sd;
        rob_id = rob;
        isStore = (t == ITYPE_STORE);
        w.rob = rob;
        w.pc = p;
        w.exc = 1'b0;
        if (t == ITYPE_LOAD || t == ITYPE_STORE) begin
            mis = 1'b0;
`ifdef MISALIGN_EXC_EN
            mis = modelMisaligned(isStore, f3, alu[1:0]);
`endif
            if (mis) begin
                w.result = alu;
                w.exc = 1'b1;
            end else begin
                m.we = isStore;
                m.addr = alu & 32'hFFFF_FFFC;
                m.wdata = modelWdata(f3, sd);
                m.wstrb = isStore ? modelStrb(f3, alu[1:0]) : 4'b0000;
                m.rdata = rdata;
                m.delay = delay;
                memQueue.push_back(m);
                w.result = isStore ? 32'h0 : modelLoad(f3, alu[1:0], rdata);
            end
        end else begin
            w.result = alu;
        end
        wbQueue.push_back(w);
        @(negedge clk);
        valid = 1'b0;
    endtask

    // Memory responder: checks each request against the queued expectation,
    // then raises mem_ready in the delay-th cycle of the request.
    initial begin
        mem_exp_t me;
        logic aborted;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (!reset && mem_req) begin
                if (memQueue.size() == 0) begin
                    checkOutput("unexpected_req", 32'(mem_req), 32'd0);
                    mem_ready = 1'b1;
                    mem_rdata = 32'h0;
                end else begin
                    me = memQueue.pop_front();
                    aborted = 1'b0;
                    checkOutput("mem_we", 32'(mem_we), 32'(me.we));
                    checkOutput("mem_addr", mem_addr, me.addr);
                    checkOutput("mem_wstrb", 32'(mem_wstrb), 32'(me.wstrb));
                    if (me.we) checkOutput("mem_wdata", mem_wdata, me.wdata);
                    for (int k = 1; k < me.delay; k++) begin
                        @(negedge clk);
                        if (reset) begin
                            aborted = 1'b1;
                            break;
                        end
                        checkOutput("req_held", 32'(mem_req), 32'd1);
                        checkOutput("addr_held", mem_addr, me.addr);
                    end
                    if (!aborted) begin
                        mem_ready = 1'b1;
                        mem_rdata = me.rdata;
                    end
                end
            end
        end
    end

    // Writeback monitor: a completion is consumed at the rising edge where
    // wb_valid is high and wb_stall is low.
    initial begin
        wb_exp_t we;
        forever begin
            @(negedge clk);
            #2;
            if (!reset && wb_valid && !wb_stall) begin
                if (wbQueue.size() == 0) begin
                    checkOutput("spurious_wb", 32'(wb_valid), 32'd0);
                end else begin
                    we = wbQueue.pop_front();
                    checkOutput("wb_rob_id", 32'(wb_rob_id), 32'(we.rob));
                    checkOutput("wb_pc", wb_pc, we.pc);
                    checkOutput("wb_result", wb_result, we.result);
                    checkOutput("wb_exc", 32'(wb_exc), 32'(we.exc));
                end
            end
        end
    end

    initial begin
        int n;
        logic [1:0]  t;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] heldResult;
        logic [6:0]  heldRob;

        reset = 1'b1;
        valid = 1'b0;
        instruction_type = ITYPE_ALU;
        pc = 32'h0;
        funct3 = 3'b000;
        aluResult = 32'h0;
        s2 = 32'h0;
        rob_id = 7'h0;
        wb_stall = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst_stall", 32'(stall_out), 32'd0);
        checkOutput("rst_wb_result", wb_result, 32'd0);
        checkOutput("rst_wstrb", 32'(mem_wstrb), 32'd0);
        #2 reset = 1'b0;

        // ALU pass-through, latency 1
        applyStimulus(ITYPE_ALU, 32'h40, 3'b000, 32'd7, 32'h0, 7'd2, 0, 32'h0);
        #1;
        checkOutput("alu_wb_valid", 32'(wb_valid), 32'd1);
        checkOutput("alu_wb_result", wb_result, 32'd7);
        checkOutput("alu_no_req", 32'(mem_req), 32'd0);

        // LB 0x103 with ready in the third wait cycle
        applyStimulus(ITYPE_LOAD, 32'h44, 3'b000, 32'h103, 32'h0, 7'd3, 3, 32'h80FF_FF01);
        n = 0;
        while (stall_out && n < 20) begin
            n++;
            @(negedge clk);
        end
        checkOutput("lb_stall_cycles", 32'(n), 32'd3);
        #1;
        checkOutput("lb_result", wb_result, 32'hFFFF_FF80);

        // SH 0x102
        applyStimulus(ITYPE_STORE, 32'h48, 3'b001, 32'h102, 32'hABCD_1234, 7'd4, 1, 32'h0);
        #1;
        checkOutput("sh_addr", mem_addr, 32'h100);
        checkOutput("sh_wstrb", 32'(mem_wstrb), 32'hC);
        checkOutput("sh_wdata", mem_wdata, 32'h1234_1234);

        // Misaligned word load
        applyStimulus(ITYPE_LOAD, 32'h4C, 3'b010, 32'h101, 32'h0, 7'd5, 1, 32'h1122_3344);
`ifdef MISALIGN_EXC_EN
        #1;
        checkOutput("mis_no_req", 32'(mem_req), 32'd0);
        checkOutput("mis_exc", 32'(wb_exc), 32'd1);
        checkOutput("mis_result", wb_result, 32'h101);
`endif

        // Non-standard funct3 falls back to a word access
        applyStimulus(ITYPE_LOAD, 32'h50, 3'b011, 32'h204, 32'h0, 7'd6, 2, 32'hDEAD_BEEF);

        // valid=0 produces neither request nor completion
        @(negedge clk);
        instruction_type = ITYPE_LOAD;
        aluResult = 32'h300;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("novalid_req", 32'(mem_req), 32'd0);
        checkOutput("novalid_wb", 32'(wb_valid), 32'd0);

        // Mixed traffic
        for (int i = 0; i < 40; i++) begin
            t = 2'($urandom_range(0, 3));
            addr = $urandom();
            case ($urandom_range(0, 4))
                0: f3 = 3'b000;
                1: f3 = 3'b001;
                2: f3 = 3'b010;
                3: f3 = 3'b100;
                default: f3 = 3'b101;
            endcase
            if (t == ITYPE_STORE && f3[2]) f3 = 3'b010;
            applyStimulus(t, 32'h1000 + 32'(i * 4), f3, addr, $urandom(), 7'(i + 16),
                          $urandom_range(1, 3), $urandom());
        end

        // Completion held under wb_stall; a waiting instruction must not overwrite it
        applyStimulus(ITYPE_LOAD, 32'h200, 3'b010, 32'h180, 32'h0, 7'd9, 2, 32'hCAFE_F00D);
        wb_stall = 1'b1;
        n = 0;
        while (!wb_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
        checkOutput("hold_wb_valid", 32'(wb_valid), 32'd1);
        heldResult = 32'hCAFE_F00D;
        heldRob = 7'd9;
        valid = 1'b1;
        instruction_type = ITYPE_ALU;
        pc = 32'h300;
        aluResult = 32'h1234;
        rob_id = 7'h55;
        wbQueue.push_back('{rob: 7'h55, pc: 32'h300, result: 32'h1234, exc: 1'b0});
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            checkOutput("hold_stall", 32'(stall_out), 32'd1);
            checkOutput("hold_valid", 32'(wb_valid), 32'd1);
            checkOutput("hold_rob", 32'(wb_rob_id), 32'(heldRob));
            checkOutput("hold_result", wb_result, heldResult);
        end
        wb_stall = 1'b0;
        @(negedge clk);
        valid = 1'b0;

        // Reset while waiting on memory
        applyStimulus(ITYPE_LOAD, 32'h400, 3'b010, 32'h500, 32'h0, 7'd10, 10, 32'h5555_AAAA);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("wait_rst_req", 32'(mem_req), 32'd0);
        checkOutput("wait_rst_wb", 32'(wb_valid), 32'd0);
        checkOutput("wait_rst_stall", 32'(stall_out), 32'd0);
        void'(wbQueue.pop_back());
        @(negedge clk);
        @(negedge clk);
        #3 reset = 1'b0;

        // Normal operation after reset
        applyStimulus(ITYPE_BRANCH, 32'h600, 3'b000, 32'h0000_0604, 32'h0, 7'd11, 0, 32'h0);
        applyStimulus(ITYPE_LOAD, 32'h604, 3'b101, 32'h702, 32'h0, 7'd12, 1, 32'h9876_5432);

        // Drain
        n = 0;
        while ((wbQueue.size() != 0 || memQueue.size() != 0 || stall_out) && n < 100) begin
            n++;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        checkOutput("wb_queue_empty", 32'(wbQueue.size()), 32'd0);
        checkOutput("mem_queue_empty", 32'(memQueue.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
